// File: rtl/root_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : root_pkg
//  Description : Shared widths, FSM state codes and the job record used by
//                the root job dispatcher and its request FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package root_pkg;

    localparam int RADICAND_W = 10;
    localparam int DEGREE_W   = 3;
    localparam int ROOT_FRAC  = 10;
    // The largest root (degree 1) is the radicand itself, so the integer part
    // of the Q format needs as many bits as the radicand.
    localparam int ROOT_W     = RADICAND_W + ROOT_FRAC;

    // Dispatcher FSM state codes
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] root_state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    typedef struct packed {
        logic [RADICAND_W-1:0] radicand;
        logic [DEGREE_W-1:0]   degree;
    } root_job_t;

endpackage
`default_nettype wire

// File: rtl/root_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : root_req_fifo
//  Description : Synchronous FIFO of root jobs with full/empty flags.
//                Pointers carry one extra wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module root_req_fifo
    import root_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  root_job_t push_job,
    input  logic      pop,
    output root_job_t head_job,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    root_job_t        mem_q [FIFO_DEPTH];
    root_job_t        mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_job = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next-state for storage and pointers; overflow/underflow attempts are ignored
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_job;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer and storage registers; storage is pure datapath and is not reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/root_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : root_job_dispatcher
//  Description : Buffers root jobs, drives the n-th root engine one job at a
//                time and returns each Q10.10 result on a valid/ready port.
//                Optional engine watchdog enabled by ROOT_DISP_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module root_job_dispatcher
    import root_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [RADICAND_W-1:0] req_radicand,
    input  logic [DEGREE_W-1:0]   req_degree,
    output logic                  eng_in_valid,
    output logic [RADICAND_W-1:0] eng_in_data_1,
    output logic [DEGREE_W-1:0]   eng_in_data_2,
    input  logic                  eng_out_valid,
    input  logic [ROOT_W-1:0]     eng_out_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ROOT_W-1:0]     rsp_root,
    output logic [DEGREE_W-1:0]   rsp_degree,
    output logic                  rsp_err
);

    root_job_t             head_job;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  rsp_fire;
    logic                  wdog_expired;
    logic                  eng_quiet;

    root_state_t           state_q,      state_d;
    logic [RADICAND_W-1:0] eng_data_1_q, eng_data_1_d;
    logic [DEGREE_W-1:0]   eng_data_2_q, eng_data_2_d;
    logic                  rsp_valid_q,  rsp_valid_d;
    logic [ROOT_W-1:0]     rsp_root_q,   rsp_root_d;
    logic [DEGREE_W-1:0]   rsp_degree_q, rsp_degree_d;
    logic                  rsp_err_q,    rsp_err_d;

    // Ready is withheld while reset is asserted
    assign req_ready = rst_n && !fifo_full;
    assign rsp_fire  = rsp_valid_q && rsp_ready;

    root_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_valid && req_ready),
        .push_job ('{radicand: req_radicand, degree: req_degree}),
        .pop      (fifo_pop),
        .head_job (head_job),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef ROOT_DISP_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic              wdog_active;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    assign wdog_active  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign wdog_expired = wdog_active && (wdog_q == WDOG_LAST);
    // A result that straggles in after a timeout must drain before the next job
    assign eng_quiet    = !eng_out_valid;

    // Watchdog counts only while the engine owns the job
    always_comb begin
        wdog_d = '0;
        if (wdog_active && !wdog_expired) begin
            wdog_d = wdog_q + WDOG_ONE;
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expired = 1'b0;
    assign eng_quiet    = 1'b1;

    // TIMEOUT_CYC has no effect without the watchdog
    if (TIMEOUT_CYC < 1) begin : g_no_watchdog
    end
`endif

    // Job sequencing: pop, strobe the engine, capture, drain, respond
    always_comb begin
        state_d      = state_q;
        eng_data_1_d = eng_data_1_q;
        eng_data_2_d = eng_data_2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_root_d   = rsp_root_q;
        rsp_degree_d = rsp_degree_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !rsp_valid_q && !eng_out_valid) begin
                    fifo_pop = 1'b1;
                    if (head_job.degree == '0) begin
                        // Degree 0 has no root: reject without touching the engine
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_root_d   = '0;
                        rsp_degree_d = head_job.degree;
                        state_d      = ST_RESP;
                    end else begin
                        eng_data_1_d = head_job.radicand;
                        eng_data_2_d = head_job.degree;
                        state_d      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT, ST_DRAIN: begin
                if (wdog_expired) begin
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    rsp_root_d   = '0;
                    rsp_degree_d = eng_data_2_q;
                    state_d      = ST_RESP;
                end else if (state_q == ST_WAIT) begin
                    if (eng_out_valid) begin
                        rsp_root_d   = eng_out_data;
                        rsp_degree_d = eng_data_2_q;
                        rsp_err_d    = 1'b0;
                        state_d      = ST_DRAIN;
                    end
                end else if (!eng_out_valid) begin
                    // Multi-cycle engine valid has ended; result is safe to present
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d  = 1'b0;
                    eng_data_1_d = '0;
                    eng_data_2_d = '0;
                end
                if ((rsp_fire || !rsp_valid_q) && eng_quiet) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, engine operand and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            eng_data_1_q <= '0;
            eng_data_2_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_root_q   <= '0;
            rsp_degree_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            eng_data_1_q <= eng_data_1_d;
            eng_data_2_q <= eng_data_2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_root_q   <= rsp_root_d;
            rsp_degree_q <= rsp_degree_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign eng_in_valid  = (state_q == ST_LOAD);
    assign eng_in_data_1 = eng_data_1_q;
    assign eng_in_data_2 = eng_data_2_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_root      = rsp_root_q;
    assign rsp_degree    = rsp_degree_q;
    assign rsp_err       = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_root_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_root_job_dispatcher
//  Description : Self-checking bench for root_job_dispatcher with a
//                behavioural root engine (configurable latency and valid
//                length) and a queue-based reference of expected responses.
//                Timeout scenario built when ROOT_DISP_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_root_job_dispatcher;

    localparam int TB_DEPTH   = 4;
    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_radicand;
    logic [2:0]  req_degree;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid;
    logic [19:0] eng_out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [19:0] rsp_root;
    logic [2:0]  rsp_degree;
    logic        rsp_err;

    // Engine stub controls
    int eng_lat;
    int eng_ov_len;
    bit stub_mute;
    bit model_mute;
    int eng_cnt;
    int ov_left;
    bit eng_busy;

    // Bookkeeping
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rsp_count = 0;
    int eng_pulses = 0;
    int in_run = 0;
    int load_cyc = 0;
    int rsp_rise_cyc = 0;
    bit prev_rsp_valid = 1'b0;
    bit last_req_fire = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    root_job_dispatcher #(
        .FIFO_DEPTH  (TB_DEPTH),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_radicand  (req_radicand),
        .req_degree    (req_degree),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_root      (rsp_root),
        .rsp_degree    (rsp_degree),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    // Mathematical n-th root in Q10.10, truncated
    function automatic logic [19:0] root_fn(input logic [9:0] rad, input logic [2:0] deg);
        real r;
        if (deg == 3'd0) return 20'd0;
        r = $pow(real'(rad), 1.0 / real'(deg)) * 1024.0 + 1.0e-6;
        return 20'($rtoi(r));
    endfunction

    // Expected response {root, degree, err} for a job accepted now
    function automatic logic [23:0] expect_of(input logic [9:0] rad, input logic [2:0] deg);
        if (deg == 3'd0 || model_mute) return {20'd0, deg, 1'b1};
        return {root_fn(rad, deg), deg, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural engine: starts on in_valid, answers after eng_lat cycles with
    // the root of whatever operands are presented at that moment, and holds
    // out_valid for eng_ov_len cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_busy      <= 1'b0;
            eng_cnt       <= 0;
            ov_left       <= 0;
            eng_out_valid <= 1'b0;
            eng_out_data  <= 20'd0;
        end else if (ov_left != 0) begin
            ov_left <= ov_left - 1;
            if (ov_left == 1) eng_out_valid <= 1'b0;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_out_valid <= 1'b1;
                eng_out_data  <= root_fn(eng_in_data_1, eng_in_data_2);
                ov_left       <= eng_ov_len;
                eng_busy      <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (eng_in_valid && !stub_mute) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
        end
    end

    // One clock: observe settled signals just after the falling edge, update
    // the reference queue and compare completed responses, then move on.
    task automatic tick();
        logic [23:0] got;
        logic [23:0] exp;
        #1;
        cyc++;
        last_req_fire = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            in_run = 0;
            prev_rsp_valid = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                last_req_fire = 1'b1;
                exp_q.push_back(expect_of(req_radicand, req_degree));
            end
            if (rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
            prev_rsp_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                got = {rsp_root, rsp_degree, rsp_err};
                got_q.push_back(got);
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check("rsp_model", 32'(got), 32'(exp));
                end
            end
            if (eng_in_valid) begin
                in_run++;
                if (in_run == 1) begin
                    eng_pulses++;
                    load_cyc = cyc;
                end
                check("start_while_rsp", 32'(rsp_valid), 32'd0);
            end else if (in_run != 0) begin
                check("in_valid_width", in_run, 1);
                in_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic push_job(input logic [9:0] rad, input logic [2:0] deg);
        int guard;
        guard = 0;
        req_valid    = 1'b1;
        req_radicand = rad;
        req_degree   = deg;
        do begin
            tick();
            guard++;
        end while (!last_req_fire && guard < 300);
        if (!last_req_fire) check("push_timeout", 32'(last_req_fire), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int target);
        int guard;
        guard = 0;
        while (rsp_count < target && guard < 2000) begin
            tick();
            guard++;
        end
        if (rsp_count < target) check("rsp_timeout", rsp_count, target);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int pulses_before;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_radicand = '0;
        req_degree   = '0;
        rsp_ready    = 1'b0;
        eng_lat      = 2;
        eng_ov_len   = 2;
        stub_mute    = 1'b0;
        model_mute   = 1'b0;
        @(negedge clk);
        repeat (3) tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_outputs", 32'({eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid}), 32'd0);
        check("rst_rsp", 32'({rsp_root, rsp_degree, rsp_err}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Single job 64, degree 2
        rsp_ready = 1'b1;
        push_job(10'd64, 3'd2);
        wait_rsps(1);
        check("t1_rsp", 32'(got_q[got_q.size()-1]), 32'({20'h02000, 3'd2, 1'b0}));

        // Back-to-back jobs, 2-cycle engine valid
        base = rsp_count;
        push_job(10'd27, 3'd3);
        push_job(10'd1023, 3'd1);
        push_job(10'd1, 3'd7);
        wait_rsps(base + 3);
        repeat (10) tick();
        check("t2_count", rsp_count, base + 3);
        check("t2_rsp0", 32'(got_q[base]),     32'({20'h00C00, 3'd3, 1'b0}));
        check("t2_rsp1", 32'(got_q[base + 1]), 32'({20'hFFC00, 3'd1, 1'b0}));
        check("t2_rsp2", 32'(got_q[base + 2]), 32'({20'h00400, 3'd7, 1'b0}));

        // Degree 0 rejected without starting the engine
        pulses_before = eng_pulses;
        push_job(10'd5, 3'd0);
        wait_rsps(rsp_count + 1);
        check("t3_rsp", 32'(got_q[got_q.size()-1]), 32'({20'd0, 3'd0, 1'b1}));
        check("t3_no_start", eng_pulses, pulses_before);

        // Back-pressure: fill the FIFO behind an unconsumed response
        rsp_ready  = 1'b0;
        eng_ov_len = 1;
        base = rsp_count;
        for (int i = 0; i < TB_DEPTH + 1; i++) begin
            push_job(10'(100 + 37 * i), 3'(1 + (i % 7)));
        end
        repeat (10) tick();
        check("t4_full", 32'(req_ready), 32'd0);
        check("t4_rsp_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        wait_rsps(base + TB_DEPTH + 1);

        // Reset while the engine is computing
        eng_lat = 20;
        push_job(10'd100, 3'd5);
        push_job(10'd200, 3'd3);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("t5_rst_outputs", 32'({eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid}), 32'd0);
        check("t5_rst_rsp", 32'({rsp_root, rsp_degree, rsp_err}), 32'd0);
        rst_n = 1'b1;
        eng_lat = 3;
        tick();
        check("t5_fifo_empty", 32'(req_ready), 32'd1);
        pulses_before = eng_pulses;
        repeat (30) tick();
        check("t5_no_stale_job", eng_pulses, pulses_before);
        push_job(10'd16, 3'd4);
        wait_rsps(rsp_count + 1);
        check("t5_rsp", 32'(got_q[got_q.size()-1]), 32'({20'h00800, 3'd4, 1'b0}));

`ifdef ROOT_DISP_TIMEOUT_EN
        // Engine never answers: watchdog error, next job still dispatched
        rsp_ready  = 1'b0;
        stub_mute  = 1'b1;
        model_mute = 1'b1;
        push_job(10'd50, 3'd2);
        model_mute = 1'b0;
        push_job(10'd81, 3'd2);
        begin
            int guard;
            guard = 0;
            while (!rsp_valid && guard < 200) begin
                tick();
                guard++;
            end
        end
        check("t6_latency", rsp_rise_cyc - load_cyc, TB_TIMEOUT + 2);
        check("t6_err", 32'({rsp_root, rsp_degree, rsp_err}), 32'({20'd0, 3'd2, 1'b1}));
        stub_mute = 1'b0;
        rsp_ready = 1'b1;
        base = rsp_count;
        wait_rsps(base + 2);
        check("t6_next", 32'(got_q[got_q.size()-1]), 32'({20'h02400, 3'd2, 1'b0}));
`endif

        // Randomized traffic against the reference queue
        begin
            int pushed;
            int guard;
            pushed = 0;
            guard  = 0;
            while (pushed < 60 && guard < 6000) begin
                if (!req_valid && $urandom_range(0, 2) != 0) begin
                    req_valid    = 1'b1;
                    req_radicand = 10'($urandom);
                    req_degree   = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                end
                rsp_ready  = ($urandom_range(0, 3) != 0);
                eng_lat    = $urandom_range(0, 6);
                eng_ov_len = $urandom_range(1, 3);
                tick();
                guard++;
                if (last_req_fire) begin
                    pushed++;
                    req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            guard = 0;
            while (exp_q.size() != 0 && guard < 3000) begin
                rsp_ready = ($urandom_range(0, 2) != 0);
                tick();
                guard++;
            end
            check("rand_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
